// File: rtl/feature_add_ctrl.sv
// Two-stream lane-wise add controller: reads x1/x2 feature words, feeds an external adder, writes results in order.
// Optional perf counters are built only when FEATURE_ADD_CTRL_PERF_EN is defined.
module feature_add_ctrl #(
    parameter int FEATURE_WIDTH = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int LEN_WIDTH     = 16,
    parameter int RD_LATENCY    = 2,
    parameter int FIFO_DEPTH    = RD_LATENCY + 2
) (
    input  logic                       system_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      cfg_x1_base,
    input  logic [ADDR_WIDTH-1:0]      cfg_x2_base,
    input  logic [ADDR_WIDTH-1:0]      cfg_out_base,
    input  logic [LEN_WIDTH-1:0]       cfg_len,
    output logic                       x1_rd_en,
    output logic                       x2_rd_en,
    output logic [ADDR_WIDTH-1:0]      x1_rd_addr,
    output logic [ADDR_WIDTH-1:0]      x2_rd_addr,
    input  logic [FEATURE_WIDTH*8-1:0] x1_rd_data,
    input  logic [FEATURE_WIDTH*8-1:0] x2_rd_data,
    output logic [FEATURE_WIDTH*8-1:0] add_x1,
    output logic [FEATURE_WIDTH*8-1:0] add_x2,
    output logic                       add_valid,
    input  logic [FEATURE_WIDTH*8-1:0] add_result,
    input  logic                       add_result_valid,
    output logic                       out_wr_en,
    output logic [ADDR_WIDTH-1:0]      out_wr_addr,
    output logic [FEATURE_WIDTH*8-1:0] out_wr_data,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                perf_cycles,
    output logic [31:0]                perf_stalls
);
    localparam int DW    = FEATURE_WIDTH * 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    state_t state_r, state_s;

    logic [ADDR_WIDTH-1:0] x1_base_r, x2_base_r, out_base_r, x1_addr_r, x2_addr_r;
    logic [LEN_WIDTH-1:0]  len_r, issue_cnt_r, wr_cnt_r;
    logic [CNT_W-1:0]      in_flight_r, fifo_cnt_r;
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [DW-1:0]         fifo_mem_r [FIFO_DEPTH];
    logic [RD_LATENCY-1:0] vld_pipe_r;
    logic                  rd_en_r, busy_r, done_r;
    logic                  active_s, credit_s, issue_s, push_s, pop_s, accept_s;

    // Issue credit counts words still in the read/add path plus words parked in the FIFO.
    always_comb begin
        active_s = (state_r == RUN) || (state_r == DRAIN);
        credit_s = ({1'b0, in_flight_r} + {1'b0, fifo_cnt_r}) < DEPTH_C;
        issue_s  = (state_r == RUN) && (issue_cnt_r != len_r) && credit_s;
        push_s   = add_result_valid && active_s && (in_flight_r != '0);
        pop_s    = active_s && (fifo_cnt_r != '0) && out_ready && !rst;
        accept_s = (state_r == IDLE) && start;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (cfg_len == '0) ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (issue_cnt_r == len_r) state_s = DRAIN;
                else                      state_s = RUN;
            end
            DRAIN: begin
                if (wr_cnt_r == len_r) state_s = DONE;
                else                   state_s = DRAIN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Control state, config latch, issue/credit/FIFO bookkeeping and registered status.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_r     <= IDLE;
            x1_base_r   <= '0;
            x2_base_r   <= '0;
            out_base_r  <= '0;
            len_r       <= '0;
            issue_cnt_r <= '0;
            wr_cnt_r    <= '0;
            in_flight_r <= '0;
            fifo_cnt_r  <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            vld_pipe_r  <= '0;
            rd_en_r     <= 1'b0;
            x1_addr_r   <= '0;
            x2_addr_r   <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                x1_base_r   <= cfg_x1_base;
                x2_base_r   <= cfg_x2_base;
                out_base_r  <= cfg_out_base;
                len_r       <= cfg_len;
                issue_cnt_r <= '0;
                wr_cnt_r    <= '0;
            end
            rd_en_r <= issue_s;
            if (issue_s) begin
                x1_addr_r   <= x1_base_r + ADDR_WIDTH'(issue_cnt_r);
                x2_addr_r   <= x2_base_r + ADDR_WIDTH'(issue_cnt_r);
                issue_cnt_r <= issue_cnt_r + 1'b1;
            end else begin
                x1_addr_r <= '0;
                x2_addr_r <= '0;
            end
            vld_pipe_r[0] <= rd_en_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
            end
            case ({issue_s, push_s})
                2'b10:   in_flight_r <= in_flight_r + 1'b1;
                2'b01:   in_flight_r <= in_flight_r - 1'b1;
                default: in_flight_r <= in_flight_r;
            endcase
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 1'b1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 1'b1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (push_s) wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + 1'b1;
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + 1'b1;
                wr_cnt_r <= wr_cnt_r + 1'b1;
            end
            busy_r <= (state_s == RUN) || (state_s == DRAIN);
            done_r <= (state_r == DONE);
        end
    end

    // Result storage; contents are only observable through the gated write port.
    always_ff @(posedge system_clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= add_result;
    end

    assign x1_rd_en    = rd_en_r;
    assign x2_rd_en    = rd_en_r;
    assign x1_rd_addr  = x1_addr_r;
    assign x2_rd_addr  = x2_addr_r;
    // Buffer data arrives combinationally at the read latency, so operands pass straight through.
    assign add_valid   = vld_pipe_r[RD_LATENCY-1] && !rst;
    assign add_x1      = add_valid ? x1_rd_data : '0;
    assign add_x2      = add_valid ? x2_rd_data : '0;
    assign out_wr_en   = pop_s;
    assign out_wr_data = pop_s ? fifo_mem_r[rd_ptr_r] : '0;
    assign out_wr_addr = pop_s ? out_base_r + ADDR_WIDTH'(wr_cnt_r) : '0;
    assign busy        = busy_r;
    assign done        = done_r;

`ifdef FEATURE_ADD_CTRL_PERF_EN
    logic [31:0] perf_cycles_r, perf_stalls_r;

    // Saturating busy-cycle and back-pressure counters, restarted by each accepted start.
    always_ff @(posedge system_clk) begin
        if (rst || accept_s) begin
            perf_cycles_r <= 32'd0;
            perf_stalls_r <= 32'd0;
        end else begin
            if (active_s && (perf_cycles_r != 32'hFFFF_FFFF)) perf_cycles_r <= perf_cycles_r + 32'd1;
            if (active_s && (fifo_cnt_r != '0) && !out_ready && (perf_stalls_r != 32'hFFFF_FFFF))
                perf_stalls_r <= perf_stalls_r + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_r;
    assign perf_stalls = perf_stalls_r;
`else
    assign perf_cycles = 32'd0;
    assign perf_stalls = 32'd0;
`endif
endmodule

// File: doc/feature_add_ctrl.md
FEATURE_ADD_CTRL -- requirements
Module: feature_add_ctrl

Interface
REQ-001 SHALL have parameter FEATURE_WIDTH, default 16, width of one lane (8 lanes per word).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, feature-buffer word-address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, transfer-length width in words.
REQ-004 SHALL have parameter RD_LATENCY, default 2, fixed buffer read latency in cycles (>=1).
REQ-005 SHALL have parameter FIFO_DEPTH, default RD_LATENCY+2, result-buffer depth in words.
REQ-006 SHALL have ports: system_clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: start  in  1  start pulse; cfg_x1_base, cfg_x2_base, cfg_out_base  in  ADDR_WIDTH  base addresses; cfg_len  in  LEN_WIDTH  word count.
REQ-008 SHALL have ports: x1_rd_en, x2_rd_en  out  1; x1_rd_addr, x2_rd_addr  out  ADDR_WIDTH; x1_rd_data, x2_rd_data  in  FEATURE_WIDTH*8.
REQ-009 SHALL have ports: add_x1, add_x2  out  FEATURE_WIDTH*8  adder operands; add_valid  out  1; add_result  in  FEATURE_WIDTH*8; add_result_valid  in  1.
REQ-010 SHALL have ports: out_wr_en  out  1; out_wr_addr  out  ADDR_WIDTH; out_wr_data  out  FEATURE_WIDTH*8; out_ready  in  1  sink accepts write.
REQ-011 SHALL have ports: busy  out  1; done  out  1; perf_cycles, perf_stalls  out  32.

Function
REQ-012 SHALL implement FSM IDLE, RUN, DRAIN, DONE; busy=1 in RUN and DRAIN only.
REQ-013 IDLE: start=1 with cfg_len!=0 SHALL latch all cfg_* and enter RUN next cycle; start=1 with cfg_len=0 SHALL enter DONE without any read or write.
REQ-014 start SHALL be ignored outside IDLE; cfg_* changes after latching SHALL have no effect.
REQ-015 RUN: SHALL assert x1_rd_en and x2_rd_en together for issue index i (0..len-1) with addresses base+i modulo 2^ADDR_WIDTH, at most one issue per cycle.
REQ-016 An issue SHALL occur only when in_flight + fifo_count < FIFO_DEPTH (in_flight = issued reads whose adder result has not yet entered the FIFO); same-cycle FIFO pop SHALL NOT grant credit.
REQ-017 After the len-th issue SHALL enter DRAIN next cycle.
REQ-018 Exactly RD_LATENCY cycles after an issue SHALL drive add_x1/add_x2 with x1_rd_data/x2_rd_data and add_valid=1; add_valid=0 otherwise, operands don't-care.
REQ-019 Each add_result_valid=1 cycle in RUN/DRAIN SHALL push add_result into the result FIFO; adder latency is not assumed.
REQ-020 When FIFO non-empty and out_ready=1 SHALL assert out_wr_en with FIFO head data and out_wr_addr = out_base + write_count (modulo), and pop; out_wr_en=0 when out_ready=0.
REQ-021 Write order SHALL equal issue order; no word dropped or duplicated.
REQ-022 DRAIN: when write_count reaches len SHALL enter DONE; DONE SHALL assert done=1 for exactly one cycle then return to IDLE.
REQ-023 add_result_valid in IDLE or DONE SHALL be ignored.

Reset
REQ-024 rst=1 at any clock edge SHALL force IDLE, clear counters, FIFO, latency pipeline and in-flight state, including mid-transfer.
REQ-025 During and after reset all outputs SHALL be 0 (rd_en, add_valid, out_wr_en, busy, done, addresses, data, perf counters).

Configuration
REQ-026 Macro FEATURE_ADD_CTRL_PERF_EN SHALL, when defined, make perf_cycles count busy cycles and perf_stalls count cycles with FIFO non-empty and out_ready=0, both cleared on accepted start, saturating at 2^32-1.
REQ-027 Without FEATURE_ADD_CTRL_PERF_EN, perf_cycles and perf_stalls SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-028 len=4, bases 0x10/0x20/0x30, out_ready=1, adder 1 cycle -> reads 0x10..0x13/0x20..0x23, writes 0x30..0x33 with lane-wise sums, one done pulse.
REQ-029 len=8, out_ready=0 for 20 cycles after start -> issues stop after FIFO_DEPTH words outstanding, perf_stalls counts, all 8 written in order after release.
REQ-030 len=0 start -> no rd_en/out_wr_en, done=1 two cycles after start, busy never 1.
REQ-031 x1 base 0xFFFE, len=4 -> x1 addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-032 rst=1 mid-transfer after 3 writes of len=10 -> IDLE next cycle, late add_result_valid ignored, new start len=2 completes with exactly 2 writes.
REQ-033 start re-pulsed during RUN with different cfg_len -> ignored, original length completes.
